// File: rtl/bus_arbiter_rr8.sv
// Round-robin owner arbiter for the TMP8 internal bus: 8 masters, tenure held
// until release, hold-limit timer, and a single turnaround cycle between tenures.
module bus_arbiter_rr8 #(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic [7:0] done,
   output logic [7:0] grant,
   output logic [2:0] grant_idx,
   output logic       grant_valid,
   output logic       timeout
);

   typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

   state_t            state, state_nx;
   logic [2:0]        ptr, ptr_nx;
   logic [2:0]        idx_nx;
   logic [HOLD_W-1:0] cnt, cnt_nx;
   logic              valid_nx, timeout_nx;

   logic [2:0]        winner, cand;
   logic              any_req;
   logic              rel_done, rel_drop, rel_limit;

   // Scan from farthest to nearest so the master just after ptr wins;
   // offset 8 wraps to ptr itself, making the last owner lowest priority.
   always_comb begin
      winner  = ptr;
      any_req = 1'b0;
      cand    = ptr;
      for (int k = 8; k >= 1; k--) begin
         cand = ptr + 3'(k);
         if (req[cand]) begin
            winner  = cand;
            any_req = 1'b1;
         end
      end
   end

   assign rel_done  = done[grant_idx];
   assign rel_drop  = ~req[grant_idx];
   assign rel_limit = (cnt == HOLD_W'(MAX_HOLD - 1));

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_nx   = state;
      ptr_nx     = ptr;
      idx_nx     = grant_idx;
      valid_nx   = grant_valid;
      cnt_nx     = cnt;
      timeout_nx = 1'b0;
      unique case (state)
         IDLE, GAP: begin
            cnt_nx = '0;
            if (any_req) begin
               state_nx = OWN;
               idx_nx   = winner;
               valid_nx = 1'b1;
            end else begin
               state_nx = IDLE;
               valid_nx = 1'b0;
            end
         end
         OWN: begin
            if (rel_done || rel_drop || rel_limit) begin
               state_nx   = GAP;
               ptr_nx     = grant_idx;
               valid_nx   = 1'b0;
               cnt_nx     = '0;
               // A forced release only counts when the owner had not let go anyway.
               timeout_nx = rel_limit & ~rel_done & ~rel_drop;
            end else begin
               cnt_nx = cnt + HOLD_W'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            valid_nx = 1'b0;
            cnt_nx   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= 3'd7;
         cnt         <= '0;
         grant_idx   <= 3'd0;
         grant_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_nx;
         ptr         <= ptr_nx;
         cnt         <= cnt_nx;
         grant_idx   <= idx_nx;
         grant_valid <= valid_nx;
         timeout     <= timeout_nx;
      end
   end

   assign grant = grant_valid ? (8'h01 << grant_idx) : 8'h00;

endmodule

// File: tb/tb_bus_arbiter_rr8.sv
// Self-checking bench for bus_arbiter_rr8: per-scenario tasks push
// {req, done, expected outputs} entries, then pop and compare cycle by cycle.
module tb_bus_arbiter_rr8;

   typedef struct packed {
      logic [7:0] g;
      logic [2:0] idx;
      logic       v;
      logic       to;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] done;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] sreq[$];
   logic [7:0] sdone[$];
   obs_t       sb[$];

   bus_arbiter_rr8 #(.MAX_HOLD(16), .HOLD_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
      $fatal(1);
   end

   function automatic obs_t cur();
      return {grant, grant_idx, grant_valid, timeout};
   endfunction

   function automatic obs_t mk(input logic [7:0] g, input logic [2:0] i,
                               input logic v, input logic t);
      return {g, i, v, t};
   endfunction

   function automatic logic [7:0] oh(input int i);
      logic [7:0] b;
      b = 8'h01;
      return b << i;
   endfunction

   task automatic add(input logic [7:0] r, input logic [7:0] d, input obs_t e);
      sreq.push_back(r);
      sdone.push_back(d);
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      req  = 8'h00;
      done = 8'h00;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      obs_t e;
      rst_n = 1'b0;
      req   = 8'hFF;
      done  = 8'h00;
      #1;
      e = mk(8'h00, 3'd0, 1'b0, 1'b0);
      n_tests++;
      if (cur() !== e) begin
         n_fail++;
         $display("FAIL reset_immediate: got %h required %h", cur(), e);
      end
      add(8'hFF, 8'h00, mk(8'h00, 3'd0, 1'b0, 1'b0));
      add(8'hFF, 8'hFF, mk(8'h00, 3'd0, 1'b0, 1'b0));
      while (sb.size() > 0) begin
         req  = sreq.pop_front();
         done = sdone.pop_front();
         tick();
         e = sb.pop_front();
         n_tests++;
         if (cur() !== e) begin
            n_fail++;
            $display("FAIL reset_held: got %h required %h", cur(), e);
         end
      end
   endtask

   task automatic test_rotation();
      obs_t e;
      @(negedge clk);
      rst_n = 1'b1;
      add(8'hFF, 8'h00, mk(8'h01, 3'd0, 1'b1, 1'b0));
      for (int i = 0; i < 8; i++) begin
         add(8'hFF, 8'h00, mk(oh(i), 3'(i), 1'b1, 1'b0));
         add(8'hFF, oh(i), mk(8'h00, 3'(i), 1'b0, 1'b0));
         add(8'hFF, 8'h00, mk(oh((i + 1) % 8), 3'((i + 1) % 8), 1'b1, 1'b0));
      end
      while (sb.size() > 0) begin
         req  = sreq.pop_front();
         done = sdone.pop_front();
         tick();
         e = sb.pop_front();
         n_tests++;
         if (cur() !== e) begin
            n_fail++;
            $display("FAIL rotation: got %h required %h", cur(), e);
         end
      end
   endtask

   task automatic test_hold_timeout();
      obs_t e;
      settle();
      for (int k = 0; k < 16; k++) add(8'h08, 8'h00, mk(8'h08, 3'd3, 1'b1, 1'b0));
      add(8'h08, 8'h00, mk(8'h00, 3'd3, 1'b0, 1'b1));
      add(8'h08, 8'h00, mk(8'h08, 3'd3, 1'b1, 1'b0));
      // Second tenure: master 4 joins during the last cycle and wins the GAP.
      for (int k = 1; k < 16; k++) add(8'h08, 8'h00, mk(8'h08, 3'd3, 1'b1, 1'b0));
      add(8'h18, 8'h00, mk(8'h00, 3'd3, 1'b0, 1'b1));
      add(8'h18, 8'h00, mk(8'h10, 3'd4, 1'b1, 1'b0));
      while (sb.size() > 0) begin
         req  = sreq.pop_front();
         done = sdone.pop_front();
         tick();
         e = sb.pop_front();
         n_tests++;
         if (cur() !== e) begin
            n_fail++;
            $display("FAIL hold_timeout: got %h required %h", cur(), e);
         end
      end
   endtask

   task automatic test_foreign_done();
      obs_t e;
      settle();
      add(8'h04, 8'h00, mk(8'h04, 3'd2, 1'b1, 1'b0));
      add(8'h25, 8'h20, mk(8'h04, 3'd2, 1'b1, 1'b0));
      add(8'h25, 8'h00, mk(8'h04, 3'd2, 1'b1, 1'b0));
      add(8'h25, 8'h04, mk(8'h00, 3'd2, 1'b0, 1'b0));
      add(8'h25, 8'h00, mk(8'h20, 3'd5, 1'b1, 1'b0));
      while (sb.size() > 0) begin
         req  = sreq.pop_front();
         done = sdone.pop_front();
         tick();
         e = sb.pop_front();
         n_tests++;
         if (cur() !== e) begin
            n_fail++;
            $display("FAIL foreign_done: got %h required %h", cur(), e);
         end
      end
   endtask

   task automatic test_drop_req();
      obs_t e;
      settle();
      add(8'h40, 8'h00, mk(8'h40, 3'd6, 1'b1, 1'b0));
      add(8'h40, 8'h00, mk(8'h40, 3'd6, 1'b1, 1'b0));
      add(8'h00, 8'h00, mk(8'h00, 3'd6, 1'b0, 1'b0));
      add(8'h00, 8'h00, mk(8'h00, 3'd6, 1'b0, 1'b0));
      add(8'h00, 8'hFF, mk(8'h00, 3'd6, 1'b0, 1'b0));
      add(8'h40, 8'h00, mk(8'h40, 3'd6, 1'b1, 1'b0));
      while (sb.size() > 0) begin
         req  = sreq.pop_front();
         done = sdone.pop_front();
         tick();
         e = sb.pop_front();
         n_tests++;
         if (cur() !== e) begin
            n_fail++;
            $display("FAIL drop_req: got %h required %h", cur(), e);
         end
      end
   endtask

   task automatic test_done_at_limit();
      obs_t e;
      settle();
      for (int k = 0; k < 16; k++) add(8'h40, 8'h00, mk(8'h40, 3'd6, 1'b1, 1'b0));
      add(8'h40, 8'h40, mk(8'h00, 3'd6, 1'b0, 1'b0));
      add(8'h40, 8'h00, mk(8'h40, 3'd6, 1'b1, 1'b0));
      while (sb.size() > 0) begin
         req  = sreq.pop_front();
         done = sdone.pop_front();
         tick();
         e = sb.pop_front();
         n_tests++;
         if (cur() !== e) begin
            n_fail++;
            $display("FAIL done_at_limit: got %h required %h", cur(), e);
         end
      end
   endtask

   task automatic test_reset_mid();
      obs_t e;
      settle();
      add(8'h08, 8'h00, mk(8'h08, 3'd3, 1'b1, 1'b0));
      add(8'h08, 8'h00, mk(8'h08, 3'd3, 1'b1, 1'b0));
      while (sb.size() > 0) begin
         req  = sreq.pop_front();
         done = sdone.pop_front();
         tick();
         e = sb.pop_front();
         n_tests++;
         if (cur() !== e) begin
            n_fail++;
            $display("FAIL reset_mid_setup: got %h required %h", cur(), e);
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      e = mk(8'h00, 3'd0, 1'b0, 1'b0);
      n_tests++;
      if (cur() !== e) begin
         n_fail++;
         $display("FAIL reset_mid_async: got %h required %h", cur(), e);
      end
      req = 8'h88;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      add(8'h88, 8'h00, mk(8'h08, 3'd3, 1'b1, 1'b0));
      add(8'h88, 8'h08, mk(8'h00, 3'd3, 1'b0, 1'b0));
      add(8'h88, 8'h00, mk(8'h80, 3'd7, 1'b1, 1'b0));
      while (sb.size() > 0) begin
         req  = sreq.pop_front();
         done = sdone.pop_front();
         tick();
         e = sb.pop_front();
         n_tests++;
         if (cur() !== e) begin
            n_fail++;
            $display("FAIL reset_mid_after: got %h required %h", cur(), e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_hold_timeout();
      test_foreign_done();
      test_drop_req();
      test_done_at_limit();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
